// File: rtl/spk_out_if.sv
// Router-side link of the spike output block: flit valid/data outward, credit return inward.
interface spk_out_if #(
    parameter int FW = 59
);
    logic          spk_out_router_vld;
    logic [FW-1:0] spk_out_router_flit;
    logic          router_spk_out_credit;

    modport master (
        output spk_out_router_vld,
        output spk_out_router_flit,
        input  router_spk_out_credit
    );

    modport slave (
        input  spk_out_router_vld,
        input  spk_out_router_flit,
        output router_spk_out_credit
    );
endinterface

// File: rtl/spk_out.sv
// Spike/config-reply output stage: queues spikes and config replies, walks the destination
// table and emits credit-controlled flits. Define SPK_OUT_MULTICAST_EN for the full table walk.
//
// state  | meaning
// IDLE   | waiting; config replies have priority over spikes
// LOOKUP | read destination entry at ptr
// SEND   | emit spike flit for the entry (stall without credit)
// REPLY  | emit config reply flit (stall without credit)
module spk_out #(
    parameter int FW          = 59,
    parameter int CDW         = 21,
    parameter int SW          = 24,
    parameter int DST_WIDTH   = 21,
    parameter int DST_DEPTH   = 4,
    parameter int CREDIT_INIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 soma_spk_out_fire,
    input  logic [SW-1:0]        config_spk_out_neuid,
    output logic                 spk_out_soma_full,
    output logic                 spk_out_ovf,
    input  logic                 config_spk_out_we,
    input  logic [CDW-1:0]       config_spk_out_wdata,
    output logic                 spk_out_conifg_full,
    input  logic                 config_spk_out_dst_we,
    input  logic [DST_DEPTH-1:0] config_spk_out_dst_waddr,
    input  logic [DST_WIDTH-1:0] config_spk_out_dst_wdata,
    input  logic                 config_spk_out_dst_re,
    input  logic [DST_DEPTH-1:0] config_spk_out_dst_raddr,
    output logic [DST_WIDTH-1:0] config_spk_out_dst_rdata,
    spk_out_if.master            rtr
);
    localparam int HW = DST_WIDTH - 2;
    localparam logic [2:0] CR_INIT = 3'(CREDIT_INIT);

    typedef enum logic [1:0] {IDLE, LOOKUP, SEND, REPLY} state_t;

    state_t               state;
    logic [DST_DEPTH-1:0] ptr;
    logic [2:0]           credit;
    logic                 entry_vld;
    logic [HW-1:0]        entry_hdr;
    logic                 vld_q;
    logic [FW-1:0]        flit_q;
    logic                 ovf_q;

    logic [SW-1:0]  spk_mem [8];
    logic [2:0]     spk_wr, spk_rd;
    logic [3:0]     spk_cnt;
    logic           spk_full, spk_push, spk_pop;
    logic [SW-1:0]  spk_head;

    logic [CDW-1:0] cfg_mem [4];
    logic [1:0]     cfg_wr, cfg_rd;
    logic [2:0]     cfg_cnt;
    logic           cfg_full, cfg_push, cfg_pop;
    logic [CDW-1:0] cfg_head;

    logic [DST_WIDTH-1:0] dst_tbl [2**DST_DEPTH];
    logic [DST_WIDTH-1:0] rdata_q;

    logic send_go, emit_spk, emit_cfg, emit, walk_done, credit_in;
    logic [FW-1:0] spk_flit, cfg_flit;

    assign spk_full = (spk_cnt == 4'd8);
    assign spk_push = soma_spk_out_fire && !spk_full;
    assign spk_head = spk_mem[spk_rd];
    assign cfg_full = (cfg_cnt == 3'd4);
    assign cfg_push = config_spk_out_we && !cfg_full;
    assign cfg_head = cfg_mem[cfg_rd];

    assign credit_in = rtr.router_spk_out_credit;
    assign send_go   = (state == SEND) && (!entry_vld || credit != 3'd0);
    assign emit_spk  = send_go && entry_vld;
    assign emit_cfg  = (state == REPLY) && (credit != 3'd0);
    assign emit      = emit_spk || emit_cfg;
    assign spk_pop   = send_go && walk_done;
    assign cfg_pop   = emit_cfg;

`ifdef SPK_OUT_MULTICAST_EN
    logic entry_last;
    assign walk_done = entry_last || (&ptr);
`else
    assign walk_done = 1'b1;
`endif

    always_comb begin
        spk_flit = '0;
        spk_flit[FW-1 -: 3]  = 3'b000;
        spk_flit[FW-4 -: HW] = entry_hdr;
        spk_flit[SW-1:0]     = spk_head;
        cfg_flit = '0;
        cfg_flit[FW-1 -: 3]  = 3'b100;
        cfg_flit[CDW-1:0]    = cfg_head;
    end

    // Storage arrays carry no reset; only pointers and counts define FIFO contents.
    always_ff @(posedge clk) begin
        if (spk_push) spk_mem[spk_wr] <= config_spk_out_neuid;
        if (cfg_push) cfg_mem[cfg_wr] <= config_spk_out_wdata;
        if (config_spk_out_dst_we) dst_tbl[config_spk_out_dst_waddr] <= config_spk_out_dst_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spk_wr  <= '0;
            spk_rd  <= '0;
            spk_cnt <= '0;
            cfg_wr  <= '0;
            cfg_rd  <= '0;
            cfg_cnt <= '0;
            ovf_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (spk_push) spk_wr <= spk_wr + 3'd1;
            if (spk_pop)  spk_rd <= spk_rd + 3'd1;
            if (spk_push && !spk_pop)      spk_cnt <= spk_cnt + 4'd1;
            else if (spk_pop && !spk_push) spk_cnt <= spk_cnt - 4'd1;
            if (cfg_push) cfg_wr <= cfg_wr + 2'd1;
            if (cfg_pop)  cfg_rd <= cfg_rd + 2'd1;
            if (cfg_push && !cfg_pop)      cfg_cnt <= cfg_cnt + 3'd1;
            else if (cfg_pop && !cfg_push) cfg_cnt <= cfg_cnt - 3'd1;
            if (soma_spk_out_fire && spk_full) ovf_q <= 1'b1;
            // Read-before-write: a same-cycle write to this address is seen on the next read.
            if (config_spk_out_dst_re) rdata_q <= dst_tbl[config_spk_out_dst_raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            credit    <= CR_INIT;
            entry_vld <= 1'b0;
            entry_hdr <= '0;
`ifdef SPK_OUT_MULTICAST_EN
            entry_last <= 1'b0;
`endif
            vld_q     <= 1'b0;
            flit_q    <= '0;
        end else begin
            vld_q <= 1'b0;
            // A flit and a returned credit in the same cycle cancel out.
            if (emit && !credit_in)
                credit <= credit - 3'd1;
            else if (!emit && credit_in && credit < CR_INIT)
                credit <= credit + 3'd1;

            case (state)
                IDLE: begin
                    if (cfg_cnt != 3'd0) begin
                        state <= REPLY;
                    end else if (spk_cnt != 4'd0) begin
                        ptr   <= '0;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    entry_vld <= dst_tbl[ptr][0];
                    entry_hdr <= dst_tbl[ptr][DST_WIDTH-1:2];
`ifdef SPK_OUT_MULTICAST_EN
                    entry_last <= dst_tbl[ptr][1];
`endif
                    state <= SEND;
                end
                SEND: begin
                    if (send_go) begin
                        if (emit_spk) begin
                            vld_q  <= 1'b1;
                            flit_q <= spk_flit;
                        end
                        if (walk_done) begin
                            state <= IDLE;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= LOOKUP;
                        end
                    end
                end
                REPLY: begin
                    if (emit_cfg) begin
                        vld_q  <= 1'b1;
                        flit_q <= cfg_flit;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign spk_out_soma_full        = spk_full;
    assign spk_out_ovf              = ovf_q;
    assign spk_out_conifg_full      = cfg_full;
    assign config_spk_out_dst_rdata = rdata_q;
    assign rtr.spk_out_router_vld   = vld_q;
    assign rtr.spk_out_router_flit  = flit_q;
endmodule

// File: doc/spk_out.md
SPK_OUT -- requirements
Module: spk_out

Interface
REQ-001 SHALL have parameter FW, default 59, flit width.
REQ-002 SHALL have parameter CDW, default 21, config reply data width.
REQ-003 SHALL have parameter SW, default 24, spike neuron-id width.
REQ-004 SHALL have parameter DST_WIDTH, default 21, destination entry width.
REQ-005 SHALL have parameter DST_DEPTH, default 4, destination table address width (16 entries).
REQ-006 SHALL have parameter CREDIT_INIT, default 4, initial router credits.
REQ-007 SHALL have ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- soma_spk_out_fire  in  1  spike valid.
- config_spk_out_neuid  in  SW  spike neuron id.
- spk_out_soma_full  out  1  spike FIFO full.
- spk_out_ovf  out  1  sticky spike-drop flag.
- config_spk_out_we  in  1  config reply push.
- config_spk_out_wdata  in  CDW  config reply data.
- spk_out_conifg_full  out  1  config FIFO full.
- config_spk_out_dst_we  in  1  table write.
- config_spk_out_dst_waddr  in  DST_DEPTH  table write address.
- config_spk_out_dst_wdata  in  DST_WIDTH  table write data.
- config_spk_out_dst_re  in  1  table read.
- config_spk_out_dst_raddr  in  DST_DEPTH  table read address.
- config_spk_out_dst_rdata  out  DST_WIDTH  table read data.
- spk_out_router_vld  out  1  flit valid, one cycle per flit.
- spk_out_router_flit  out  FW  flit.
- router_spk_out_credit  in  1  one credit returned.

Function
REQ-008 Spike FIFO SHALL hold 8 entries of SW bits; config FIFO SHALL hold 4 entries of CDW bits; both first-word-fall-through.
REQ-009 Fire while spike FIFO full SHALL drop the spike and set spk_out_ovf; we while config FIFO full SHALL be ignored.
REQ-010 Destination entry: bit0 = valid, bit1 = last, [20:2] = 19-bit route header.
REQ-011 Config port read SHALL return the entry on config_spk_out_dst_rdata one cycle after re; simultaneous write to the same address SHALL return the old data.
REQ-012 Spike flit: [58:56]=3'b000, [55:37]=route header, [36:24]=0, [23:0]=neuid; config flit: [58:56]=3'b100, [55:21]=0, [20:0]=data.
REQ-013 FSM states IDLE, LOOKUP, SEND, REPLY.
REQ-014 IDLE: config FIFO non-empty -> REPLY; else spike FIFO non-empty -> LOOKUP with entry pointer 0; config wins when both pending.
REQ-015 LOOKUP SHALL read the table entry at the pointer, one cycle, then go to SEND.
REQ-016 SEND: valid entry with credit>0 SHALL emit one flit; invalid entry SHALL emit nothing; no credit SHALL stall in SEND.
REQ-017 After SEND, last=1 or pointer=15 SHALL pop the spike and go to IDLE; otherwise pointer+1 -> LOOKUP.
REQ-018 REPLY with credit>0 SHALL emit one config flit, pop, go to IDLE.
REQ-019 Credit counter, 3 bits: -1 per flit, +1 per credit pulse, unchanged when both in same cycle; never exceeds CREDIT_INIT.
REQ-020 Latency: spike written at cycle N into empty FIFO, idle FSM, credits available -> first flit valid at N+3.
REQ-021 Table writes during a walk SHALL affect only entries not yet read.

Reset
REQ-022 rst_n low SHALL immediately clear both FIFOs, set FSM to IDLE, pointer to 0, credits to CREDIT_INIT, and drive all outputs to 0; table contents undefined.
REQ-023 Reset mid-walk SHALL abandon the spike with no further flits.

Configuration
REQ-024 With SPK_OUT_MULTICAST_EN defined, the full table walk of REQ-017 SHALL apply.
REQ-025 Without SPK_OUT_MULTICAST_EN, only entry 0 SHALL be used: at most one flit per spike, spike discarded if entry 0 invalid.

Verification
REQ-026 Entry0={hdr 0x1,last=1,valid=1}; fire id 0x00ABCD -> one flit 0x00001_0000_ABCD form, type 000, at N+3.
REQ-027 Entries 0..2 valid, entry 2 last, multicast on -> three flits, headers of entries 0,1,2 in order.
REQ-028 Credits 0, spike pending -> no flit; one credit pulse -> exactly one flit.
REQ-029 Config push 0x12345 and spike pushed same cycle -> config flit first, then spike flit.
REQ-030 Nine back-to-back fires, no credits -> spk_out_soma_full=1 after eighth, ovf=1 after ninth, eight spikes later delivered.
REQ-031 rst_n low during a three-entry walk after first flit -> no further flits, credits=4, outputs 0.
